// File: rtl/lsq_mc.sv
// lsq_mc: multi-channel request queue serialised onto a memory bus, with response/interrupt decode
module lsq_mc #(
  parameter int WIDTH = 128,
  parameter int BUS_W = 64,
  parameter int NCH   = 2,
  parameter int DEPTH = 8,
  parameter int PRIO  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NCH*WIDTH-1:0]         i_req_data,
  input  logic [NCH-1:0]               i_req_vld,
  output logic [NCH-1:0]               o_req_rd,
  output logic [BUS_W-1:0]             o_bus,
  output logic                         o_bus_vld,
  input  logic                         i_bus_gnt,
  input  logic [BUS_W-1:0]             i_bus,
  output logic [NCH-1:0]               o_rsp_vld,
  output logic [14:0]                  o_rsp_addr,
  output logic [31:0]                  o_rsp_data,
  output logic                         o_interrupt,
  output logic [31:0]                  o_interrupt_vec,
  input  logic                         i_int_ack,
  output logic                         o_lsq_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_lsq_count
);
  localparam int NB = WIDTH / BUS_W;
  localparam int AW = $clog2(DEPTH);
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int PW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] beat;
  logic [PW-1:0] rr, win, idx;
  logic any, acc, pop, last, rv, ri, unused_bits;
  logic [2:0] dst;
  // Round-robin takes the first hit from rr; fixed priority lets later (higher) hits overwrite.
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = PW'(PRIO != 0 ? k : (int'(rr) + k) % NCH);
      if (i_req_vld[idx] && (PRIO != 0 || !any)) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
  assign acc = rst && any && !o_lsq_full;
  assign o_req_rd = acc ? (NCH'(1) << win) : '0;
  assign last = beat == BW'(NB - 1);
  assign o_bus_vld = o_lsq_count != '0;
  assign pop = o_bus_vld && i_bus_gnt && last;
  assign o_lsq_full = o_lsq_count == CW'(DEPTH);
  assign o_bus = BUS_W'(mem[rd_ptr] >> (int'(beat) * BUS_W));
  assign rv = i_bus[59];
  assign ri = i_bus[63];
  assign dst = i_bus[58:56];
  assign unused_bits = ^{i_bus[62:60], i_bus[55:47], i_bus >> 64};
  always_ff @(posedge clk)
    if (acc) mem[wr_ptr] <= WIDTH'(i_req_data >> (int'(win) * WIDTH));
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      beat <= '0;
      rr <= '0;
      o_lsq_count <= '0;
    end else begin
      if (acc) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr <= int'(win) == NCH - 1 ? '0 : win + 1'b1;
      end
      if (o_bus_vld && i_bus_gnt) beat <= last ? '0 : beat + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      o_lsq_count <= o_lsq_count + CW'(acc) - CW'(pop);
    end
  end
  // Ack and a new interrupt in the same cycle re-arms with the new vector.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_rsp_vld <= '0;
      o_rsp_addr <= '0;
      o_rsp_data <= '0;
      o_interrupt <= 1'b0;
      o_interrupt_vec <= '0;
    end else begin
      o_rsp_vld <= '0;
      if (rv && !ri && int'(dst) < NCH) begin
        o_rsp_vld <= NCH'(1) << dst;
        o_rsp_addr <= i_bus[46:32];
        o_rsp_data <= i_bus[31:0];
      end
      if (rv && ri && (!o_interrupt || i_int_ack)) begin
        o_interrupt <= 1'b1;
        o_interrupt_vec <= i_bus[31:0];
      end else if (i_int_ack) o_interrupt <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lsq_mc.sv
// tb_lsq_mc: round-robin and fixed-priority instances driven in lockstep against a queue-based model
module tb_lsq_mc;
  logic clk = 0, rst = 0, i_bus_gnt = 0, i_int_ack = 0, armed = 0;
  logic [255:0] i_req_data = '0;
  logic [1:0] i_req_vld = '0;
  logic [63:0] i_bus = '0;
  logic [1:0] e_rsp_vld;
  logic [14:0] e_addr;
  logic [31:0] e_data, e_vec;
  logic e_irq;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(int prio, int rr, logic [1:0] v);
    if (prio != 0) begin
      for (int c = 1; c >= 0; c--) if (v[c]) return c;
    end else
      for (int k = 0; k < 2; k++) if (v[(rr + k) % 2]) return (rr + k) % 2;
    return -1;
  endfunction

  function automatic logic [63:0] rspw(logic [2:0] d, logic [14:0] a, logic [31:0] x);
    return {4'b0000, 1'b1, d, 9'd0, a, x};
  endfunction

  function automatic logic [63:0] irqw(logic [31:0] x);
    return {4'b1000, 1'b1, 3'd0, 9'd0, 15'd0, x};
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      armed <= 1'b1;
      e_rsp_vld <= '0;
      e_addr <= '0;
      e_data <= '0;
      e_irq <= 1'b0;
      e_vec <= '0;
    end else begin
      e_rsp_vld <= (i_bus[59] && !i_bus[63] && i_bus[58:56] < 2) ? 2'(1 << i_bus[58:56]) : 2'b00;
      if (i_bus[59] && !i_bus[63] && i_bus[58:56] < 2) begin
        e_addr <= i_bus[46:32];
        e_data <= i_bus[31:0];
      end
      if (i_bus[59] && i_bus[63] && (!e_irq || i_int_ack)) begin
        e_irq <= 1'b1;
        e_vec <= i_bus[31:0];
      end else if (i_int_ack) e_irq <= 1'b0;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : mdl
    logic [1:0] req_rd, rsp_vld;
    logic [63:0] bus;
    logic bus_vld, irq, full;
    logic [14:0] rsp_addr;
    logic [31:0] rsp_data, vec;
    logic [3:0] cnt;
    logic [127:0] q[$];
    int beat = 0, rr = 0;
    lsq_mc #(.PRIO(g)) dut (
      .clk(clk), .rst(rst), .i_req_data(i_req_data), .i_req_vld(i_req_vld), .o_req_rd(req_rd),
      .o_bus(bus), .o_bus_vld(bus_vld), .i_bus_gnt(i_bus_gnt), .i_bus(i_bus),
      .o_rsp_vld(rsp_vld), .o_rsp_addr(rsp_addr), .o_rsp_data(rsp_data),
      .o_interrupt(irq), .o_interrupt_vec(vec), .i_int_ack(i_int_ack),
      .o_lsq_full(full), .o_lsq_count(cnt)
    );
    always @(posedge clk) begin : upd
      int w;
      bit take;
      w = pick(g, rr, i_req_vld);
      take = rst && w >= 0 && q.size() < 8;
      if (!rst) begin
        q.delete();
        beat = 0;
        rr = 0;
      end else begin
        if (q.size() != 0 && i_bus_gnt) begin
          if (beat == 1) begin
            void'(q.pop_front());
            beat = 0;
          end else beat++;
        end
        if (take) begin
          q.push_back(i_req_data[w*128 +: 128]);
          rr = (w + 1) % 2;
        end
      end
    end
    always @(negedge clk) if (armed) begin : cmp
      int w;
      logic [127:0] h;
      w = pick(g, rr, i_req_vld);
      chk($sformatf("u%0d.req_rd", g), req_rd, (rst && w >= 0 && q.size() < 8) ? 64'(1) << w : 64'(0));
      chk($sformatf("u%0d.bus_vld", g), bus_vld, q.size() != 0);
      if (q.size() != 0) begin
        h = q[0];
        chk($sformatf("u%0d.bus", g), bus, 64'(h >> (beat * 64)));
      end
      chk($sformatf("u%0d.count", g), cnt, q.size());
      chk($sformatf("u%0d.full", g), full, q.size() == 8);
      chk($sformatf("u%0d.rsp_vld", g), rsp_vld, e_rsp_vld);
      chk($sformatf("u%0d.rsp_addr", g), rsp_addr, e_addr);
      chk($sformatf("u%0d.rsp_data", g), rsp_data, e_data);
      chk($sformatf("u%0d.irq", g), irq, e_irq);
      chk($sformatf("u%0d.vec", g), vec, e_vec);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_data();
    for (int i = 0; i < 8; i++) i_req_data[i*32 +: 32] = $urandom;
  endtask

  initial begin
    repeat (2) step();
    rst = 1;
    @(negedge clk);
    chk("rst_count", mdl[0].cnt, 0);
    chk("rst_bus_vld", mdl[0].bus_vld, 0);
    chk("rst_irq", mdl[0].irq, 0);
    chk("rst_rsp_vld", mdl[0].rsp_vld, 0);
    step();
    i_req_data[127:0] = {64'hA1A2A3A4A5A6A7A8, 64'hB1B2B3B4B5B6B7B8};
    i_req_vld = 2'b01;
    @(negedge clk);
    chk("push_rd", mdl[0].req_rd, 2'b01);
    step();
    i_req_vld = 2'b00;
    i_bus_gnt = 1;
    @(negedge clk);
    chk("beat0_vld", mdl[0].bus_vld, 1);
    chk("beat0", mdl[0].bus, 64'hB1B2B3B4B5B6B7B8);
    step();
    @(negedge clk);
    chk("beat1", mdl[0].bus, 64'hA1A2A3A4A5A6A7A8);
    step();
    i_bus_gnt = 0;
    @(negedge clk);
    chk("popped", mdl[0].bus_vld, 0);
    step();
    i_bus = rspw(3'd1, 15'h1234, 32'hDEADBEEF);
    step();
    i_bus = '0;
    @(negedge clk);
    chk("rsp_strobe", mdl[0].rsp_vld, 2'b10);
    chk("rsp_addr", mdl[0].rsp_addr, 15'h1234);
    chk("rsp_data", mdl[0].rsp_data, 32'hDEADBEEF);
    step();
    i_bus = rspw(3'd5, 15'h0777, 32'h12345678);
    @(negedge clk);
    chk("rsp_one_cycle", mdl[0].rsp_vld, 2'b00);
    step();
    i_bus = '0;
    @(negedge clk);
    chk("rsp_dst5_drop", mdl[0].rsp_vld, 2'b00);
    chk("rsp_addr_hold", mdl[0].rsp_addr, 15'h1234);
    step();
    i_bus = irqw(32'h10);
    step();
    i_bus = irqw(32'h20);
    @(negedge clk);
    chk("irq_set", mdl[0].irq, 1);
    chk("irq_vec10", mdl[0].vec, 32'h10);
    step();
    i_bus = irqw(32'h30);
    i_int_ack = 1;
    @(negedge clk);
    chk("irq_keep_first", mdl[0].vec, 32'h10);
    step();
    i_bus = '0;
    @(negedge clk);
    chk("irq_ack_new", mdl[0].irq, 1);
    chk("irq_vec30", mdl[0].vec, 32'h30);
    step();
    i_int_ack = 0;
    @(negedge clk);
    chk("irq_cleared", mdl[0].irq, 0);
    step();
    rst = 0;
    step();
    rst = 1;
    i_req_vld = 2'b11;
    rnd_data();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fill_rr", mdl[0].req_rd, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("fill_prio", mdl[1].req_rd, 2'b10);
      step();
      rnd_data();
    end
    @(negedge clk);
    chk("full_rd", mdl[0].req_rd, 2'b00);
    chk("full_flag", mdl[0].full, 1);
    chk("full_count", mdl[0].cnt, 8);
    step();
    i_bus_gnt = 1;
    repeat (200) begin
      @(negedge clk);
      chk("stream_cnt", mdl[0].cnt >= 7 && mdl[0].cnt <= 8, 1);
      step();
      rnd_data();
    end
    rst = 0;
    i_bus_gnt = 0;
    step();
    rst = 1;
    repeat (3) begin
      @(negedge clk);
      chk("prio_ch1", mdl[1].req_rd, 2'b10);
      step();
    end
    i_req_vld = 2'b01;
    @(negedge clk);
    chk("prio_ch0", mdl[1].req_rd, 2'b01);
    for (int n = 0; n < 3000; n++) begin
      step();
      rst = $urandom_range(0, 299) != 0;
      i_req_vld = 2'($urandom_range(0, 3));
      rnd_data();
      i_bus_gnt = $urandom_range(0, 2) != 0;
      i_bus = {$urandom, $urandom};
      i_int_ack = $urandom_range(0, 7) == 0;
    end
    step();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
